// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: line-following drive controller for the rover.
// Conditions the raw sensor, proximity and stop inputs, decodes the line position,
// runs the drive state machine, and gates the motor enables with a PWM speed signal.
module line_follow_ctrl #(
    parameter int NSENS     = 3,
    parameter int DEB_CYC   = 4,
    parameter int LOST_TO   = 1000,
    parameter int OBST_HOLD = 500,
    parameter int PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NSENS-1:0]    induct,
    input  logic                proxim,
    input  logic                red,
    input  logic [PWM_BITS-1:0] duty,
    output logic [3:0]          motor_in,
    output logic [1:0]          motor_en,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FOLLOW   = 3'd1,
        ST_TURN_L   = 3'd2,
        ST_TURN_R   = 3'd3,
        ST_SEARCH   = 3'd4,
        ST_OBSTACLE = 3'd5,
        ST_HALT     = 3'd6
    } state_t;

    // All conditioned inputs share one vector: {red, proxim, induct}
    localparam int NIN = NSENS + 2;
    localparam logic [NIN-1:0] IN_IDLE = {2'b00, {NSENS{1'b1}}};
    localparam int C  = NSENS / 2;
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int LW = (LOST_TO > 1) ? $clog2(LOST_TO) : 1;
    localparam int HW = (OBST_HOLD > 1) ? $clog2(OBST_HOLD) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [LW-1:0] LOST_LAST = LW'(LOST_TO - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(OBST_HOLD - 1);

    localparam logic [3:0] PAT_FWD  = 4'b0101;
    localparam logic [3:0] PAT_PIVL = 4'b1001;
    localparam logic [3:0] PAT_PIVR = 4'b0110;
    localparam logic [3:0] PAT_STOP = 4'b0000;

    logic [NIN-1:0]      raw_in;
    logic [NIN-1:0]      sync_a;
    logic [NIN-1:0]      sync_b;
    logic [NIN-1:0]      filt;
    logic [DW-1:0]       deb_cnt [NIN];

    logic [NSENS-1:0]    act;
    logic                f_proxim;
    logic                f_red;
    logic                any_l;
    logic                any_r;
    logic                mid;
    state_t              dec_state;

    state_t              state_q;
    state_t              next_state;
    logic                last_dir;
    logic [LW-1:0]       lost_cnt;
    logic [HW-1:0]       hold_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic [3:0]          motor_next;
    logic [1:0]          en_next;

    assign raw_in   = {red, proxim, induct};
    assign act      = ~filt[NSENS-1:0];
    assign f_proxim = filt[NSENS];
    assign f_red    = filt[NSENS+1];
    assign state    = state_q;

    // Two-flop synchroniser; reset leaves every input at its inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= IN_IDLE;
            sync_b <= IN_IDLE;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
        end
    end

    // Per-bit debounce: filtered bit follows only after DEB_CYC differing samples in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= IN_IDLE;
            for (int i = 0; i < NIN; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync_b[i] != filt[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        filt[i]    <= sync_b[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Line-position decode from the filtered sensor mask
    always_comb begin
        any_l     = 1'b0;
        any_r     = 1'b0;
        mid       = act[C];
        dec_state = ST_SEARCH;
        for (int i = 0; i < NSENS; i++) begin
            if (i < C)      any_l = any_l | act[i];
            else if (i > C) any_r = any_r | act[i];
        end
        if (act == '0)                 dec_state = ST_SEARCH;
        else if (mid || (any_l && any_r)) dec_state = ST_FOLLOW;
        else if (any_l)                dec_state = ST_TURN_L;
        else                           dec_state = ST_TURN_R;
    end

    // Next-state logic: stop beats obstacle beats the per-state rules
    always_comb begin
        next_state = state_q;
        if (f_red) begin
            next_state = ST_IDLE;
        end else if (f_proxim && (state_q == ST_FOLLOW || state_q == ST_TURN_L ||
                                  state_q == ST_TURN_R || state_q == ST_SEARCH)) begin
            next_state = ST_OBSTACLE;
        end else begin
            case (state_q)
                ST_IDLE:   next_state = ST_FOLLOW;
                ST_FOLLOW,
                ST_TURN_L,
                ST_TURN_R: next_state = dec_state;
                ST_SEARCH: begin
                    if (dec_state != ST_SEARCH)  next_state = dec_state;
                    else if (lost_cnt == LOST_LAST) next_state = ST_HALT;
                end
                ST_OBSTACLE: begin
                    if (!f_proxim && hold_cnt == HOLD_LAST) next_state = dec_state;
                end
                ST_HALT:   next_state = ST_HALT;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Drive pattern and PWM-gated enables for the state being entered
    always_comb begin
        pwm_on     = (pwm_cnt < duty) || (&duty);
        motor_next = PAT_STOP;
        en_next    = 2'b00;
        case (next_state)
            ST_FOLLOW: begin motor_next = PAT_FWD;  en_next = {2{pwm_on}}; end
            ST_TURN_L: begin motor_next = PAT_PIVL; en_next = {2{pwm_on}}; end
            ST_TURN_R: begin motor_next = PAT_PIVR; en_next = {2{pwm_on}}; end
            ST_SEARCH: begin
                motor_next = last_dir ? PAT_PIVR : PAT_PIVL;
                en_next    = {2{pwm_on}};
            end
            default: begin motor_next = PAT_STOP; en_next = 2'b00; end
        endcase
    end

    // State, drive outputs and remembered turn direction (0 = left) update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            motor_in <= PAT_STOP;
            motor_en <= 2'b00;
            last_dir <= 1'b0;
        end else begin
            state_q  <= next_state;
            motor_in <= motor_next;
            motor_en <= en_next;
            if (next_state == ST_TURN_L)      last_dir <= 1'b0;
            else if (next_state == ST_TURN_R) last_dir <= 1'b1;
        end
    end

    // Lost-line and obstacle hold-off counters; both saturate at their limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            if (next_state == ST_SEARCH && state_q != ST_SEARCH)
                lost_cnt <= '0;
            else if (state_q == ST_SEARCH && lost_cnt != LOST_LAST)
                lost_cnt <= lost_cnt + LW'(1);

            if (next_state == ST_OBSTACLE && state_q != ST_OBSTACLE)
                hold_cnt <= '0;
            else if (state_q == ST_OBSTACLE) begin
                if (f_proxim)                   hold_cnt <= '0;
                else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    // Free-running PWM counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

endmodule

// File: tb/tb_line_follow_ctrl.sv
// tb_line_follow_ctrl: scoreboard bench for line_follow_ctrl.
// Expected outputs are queued with their due cycle when stimulus is applied
// and compared on the falling edge of the cycle they are due.
module tb_line_follow_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] induct;
    logic       proxim;
    logic       red;
    logic [7:0] duty;
    logic [3:0] motor_in;
    logic [1:0] motor_en;
    logic [2:0] state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int b;
    int e;
    int cnt_l;
    int cnt_r;

    typedef struct {
        int         due;
        string      tag;
        int         kind;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t keep[$];

    line_follow_ctrl #(
        .NSENS(3), .DEB_CYC(4), .LOST_TO(16), .OBST_HOLD(8), .PWM_BITS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .induct(induct), .proxim(proxim), .red(red),
        .duty(duty), .motor_in(motor_in), .motor_en(motor_en), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0:       return {29'd0, state};
            1:       return {28'd0, motor_in};
            default: return {30'd0, motor_en};
        endcase
    endfunction

    task automatic expectAt(input int due, input string tag, input int kind, input logic [3:0] val);
        exp_t x;
        x.due = due; x.tag = tag; x.kind = kind; x.val = val;
        sb.push_back(x);
    endtask

    task automatic applyStimulus(input logic [2:0] ind, input logic prox, input logic rd);
        induct = ind;
        proxim = prox;
        red    = rd;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare and retire every entry due this cycle
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due <= cyc) checkOutput(sb[i].tag, observe(sb[i].kind), {28'd0, sb[i].val});
            else                  keep.push_back(sb[i]);
        end
        sb = keep;
    end

    initial begin
        rst_n = 1'b0;
        duty  = 8'hFF;
        applyStimulus(3'b101, 1'b0, 1'b0);

        // Held in reset: everything stopped
        repeat (3) @(negedge clk);
        checkOutput("rst_state", {29'd0, state}, 32'd0);
        checkOutput("rst_motor_in", {28'd0, motor_in}, 32'd0);
        checkOutput("rst_motor_en", {30'd0, motor_en}, 32'd0);

        // Release: FOLLOW at once, SEARCH (pivot left) while the sensors filter in, then FOLLOW
        @(negedge clk);
        rst_n = 1'b1;
        b = cyc;
        expectAt(b + 1, "rel_follow", 0, 4'd1);
        expectAt(b + 1, "rel_fwd", 1, 4'b0101);
        expectAt(b + 2, "rel_search", 0, 4'd4);
        expectAt(b + 2, "rel_pivl", 1, 4'b1001);
        expectAt(b + 6, "rel_still_search", 0, 4'd4);
        expectAt(b + 7, "rel_found", 0, 4'd1);
        expectAt(b + 7, "rel_found_fwd", 1, 4'b0101);
        for (int i = 1; i < 27; i++) expectAt(b + i, "en_full_duty", 2, 4'b0011);
        waitCycles(30);

        // Right sensor: TURN_R exactly 7 cycles after the change
        applyStimulus(3'b011, 1'b0, 1'b0);
        b = cyc;
        expectAt(b + 6, "turnr_early", 0, 4'd1);
        expectAt(b + 7, "turnr_state", 0, 4'd3);
        expectAt(b + 7, "turnr_motor", 1, 4'b0110);
        waitCycles(10);

        // Two-cycle glitch must be filtered out
        b = cyc;
        applyStimulus(3'b110, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(3'b011, 1'b0, 1'b0);
        expectAt(b + 7, "glitch_hold1", 0, 4'd3);
        expectAt(b + 9, "glitch_hold2", 0, 4'd3);
        expectAt(b + 12, "glitch_motor", 1, 4'b0110);
        waitCycles(15);

        // Line lost after TURN_R: search pivoting right, HALT after 16 search cycles
        applyStimulus(3'b111, 1'b0, 1'b0);
        b = cyc;
        expectAt(b + 6, "lost_early", 0, 4'd3);
        expectAt(b + 7, "search_state", 0, 4'd4);
        expectAt(b + 7, "search_pivr", 1, 4'b0110);
        expectAt(b + 22, "search_last", 0, 4'd4);
        expectAt(b + 23, "halt_state", 0, 4'd6);
        expectAt(b + 23, "halt_motor", 1, 4'b0000);
        expectAt(b + 23, "halt_en", 2, 4'b0000);
        waitCycles(30);

        // HALT ignores the line returning
        applyStimulus(3'b101, 1'b0, 1'b0);
        b = cyc;
        expectAt(b + 10, "halt_held", 0, 4'd6);
        waitCycles(12);

        // Stop request leaves HALT for IDLE, clearing it goes back to FOLLOW
        applyStimulus(3'b101, 1'b0, 1'b1);
        b = cyc;
        expectAt(b + 7, "red_idle", 0, 4'd0);
        waitCycles(10);
        applyStimulus(3'b101, 1'b0, 1'b0);
        b = cyc;
        expectAt(b + 6, "red_still_idle", 0, 4'd0);
        expectAt(b + 7, "unred_follow", 0, 4'd1);
        expectAt(b + 7, "unred_fwd", 1, 4'b0101);
        expectAt(b + 12, "unred_stays", 0, 4'd1);
        waitCycles(14);

        // Left sensor: TURN_L, then lost line searches pivoting left
        applyStimulus(3'b110, 1'b0, 1'b0);
        b = cyc;
        expectAt(b + 7, "turnl_state", 0, 4'd2);
        expectAt(b + 7, "turnl_motor", 1, 4'b1001);
        waitCycles(10);
        applyStimulus(3'b111, 1'b0, 1'b0);
        b = cyc;
        e = b + 7;
        expectAt(e, "search2_state", 0, 4'd4);
        expectAt(e, "search2_pivl", 1, 4'b1001);
        // Line found on the very cycle the lost counter hits its limit: found wins
        waitCycles(16);
        applyStimulus(3'b101, 1'b0, 1'b0);
        expectAt(e + 15, "found_pre", 0, 4'd4);
        expectAt(e + 16, "found_wins", 0, 4'd1);
        expectAt(e + 16, "found_fwd", 1, 4'b0101);
        waitCycles(20);

        // Obstacle: stop, resume 8 cycles after the filtered detect falls
        applyStimulus(3'b101, 1'b1, 1'b0);
        b = cyc;
        expectAt(b + 7, "obst_state", 0, 4'd5);
        expectAt(b + 7, "obst_motor", 1, 4'b0000);
        expectAt(b + 7, "obst_en", 2, 4'b0000);
        expectAt(b + 23, "obst_hold", 0, 4'd5);
        expectAt(b + 24, "obst_resume", 0, 4'd1);
        expectAt(b + 24, "obst_resume_fwd", 1, 4'b0101);
        waitCycles(10);
        applyStimulus(3'b101, 1'b0, 1'b0);
        waitCycles(20);

        // Re-pulse during hold-off restarts the count
        applyStimulus(3'b101, 1'b1, 1'b0);
        b = cyc;
        expectAt(b + 7, "repulse_obst", 0, 4'd5);
        waitCycles(10);
        applyStimulus(3'b101, 1'b0, 1'b0);
        waitCycles(6);
        applyStimulus(3'b101, 1'b1, 1'b0);
        waitCycles(4);
        applyStimulus(3'b101, 1'b0, 1'b0);
        expectAt(b + 24, "repulse_no_early", 0, 4'd5);
        expectAt(b + 33, "repulse_hold", 0, 4'd5);
        expectAt(b + 34, "repulse_resume", 0, 4'd1);
        waitCycles(30);

        // Stop and obstacle together: stop wins
        applyStimulus(3'b101, 1'b1, 1'b1);
        b = cyc;
        expectAt(b + 7, "both_idle", 0, 4'd0);
        expectAt(b + 7, "both_en", 2, 4'b0000);
        waitCycles(10);
        applyStimulus(3'b101, 1'b0, 1'b0);
        expectAt(b + 16, "both_still_idle", 0, 4'd0);
        expectAt(b + 17, "both_follow", 0, 4'd1);
        waitCycles(20);

        // PWM duty: count enabled cycles over one full period
        duty = 8'd64;
        waitCycles(3);
        cnt_l = 0; cnt_r = 0;
        repeat (256) begin
            @(negedge clk);
            if (motor_en[1]) cnt_l++;
            if (motor_en[0]) cnt_r++;
        end
        checkOutput("pwm64_left", cnt_l, 64);
        checkOutput("pwm64_right", cnt_r, 64);

        duty = 8'd0;
        waitCycles(3);
        cnt_l = 0;
        repeat (256) begin
            @(negedge clk);
            if (motor_en != 2'b00) cnt_l++;
        end
        checkOutput("pwm0_never", cnt_l, 0);

        duty = 8'hFF;
        waitCycles(3);
        cnt_l = 0;
        repeat (256) begin
            @(negedge clk);
            if (motor_en == 2'b11) cnt_l++;
        end
        checkOutput("pwmff_always", cnt_l, 256);

        // Every queued expectation must have been retired
        waitCycles(2);
        checkOutput("sb_drained", sb.size(), 0);

        // Reset mid-cycle drops the motors immediately
        checkOutput("pre_reset_en", {30'd0, motor_en}, 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_state", {29'd0, state}, 32'd0);
        checkOutput("midrst_motor_in", {28'd0, motor_in}, 32'd0);
        checkOutput("midrst_motor_en", {30'd0, motor_en}, 32'd0);
        waitCycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
